// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared types and constants for the SPI mode-0 responder
// Contents: responder state enum, word loaded when the tx buffer is empty
// (non-echo build), and the bit-counter width helper.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_RELOAD = 2'd2
  } state_e;

  // Sliced down to DATA_W at the point of use.
  localparam logic [63:0] DEFAULT_TX_WORD = 64'h0;

  // Counter must hold the value DATA_W itself, not just DATA_W-1.
  function automatic int cnt_width(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - multi-flop synchronizer with rise/fall edge pulses
// Ports:
//   clk, reset   system clock, asynchronous active-low reset
//   d_i          asynchronous input
//   sync_o       synchronized level
//   rise_o       one-cycle pulse on a synchronized 0->1 transition
//   fall_o       one-cycle pulse on a synchronized 1->0 transition
module spi_in_sync #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Reset to the line's idle level so no edge is reported on reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = sync_q[SYNC_STAGES-1];
  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign fall_o = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_responder.sv
// rtl/spi_slave_responder.sv - SPI mode-0 slave with one-entry tx buffer
// Build option: SPI_SLAVE_ECHO_EN - empty tx buffer loads the last rx word
// instead of zero.
// Ports:
//   clk, reset        system clock (>= 8x sclk), asynchronous active-low reset
//   sclk, cs_bar, mosi asynchronous SPI inputs from the master
//   miso, miso_oe     serial output and its drive enable (high while selected)
//   tx_data/valid/ready  one-entry transmit buffer write handshake
//   rx_data, rx_valid  last complete word and its one-cycle update pulse
//   frame_active      high while the FSM is not idle
module spi_slave_responder
  import spi_slave_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_bar,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              frame_active
);

  localparam int CNT_W = cnt_width(DATA_W);

  // sclk level is never needed: all sclk timing comes from its edges.
  logic unused_sclk_level;
  logic sclk_rise, sclk_fall;
  logic cs_s, sel, desel;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, bit_cnt_inc;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d, rx_word;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_pend_q, rx_pend_d;
  logic              rx_valid_q;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic              buf_full_q, buf_full_d;
  logic              load, tx_write;
  logic [DATA_W-1:0] dflt_word, load_word;

  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b0)
  ) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (sclk),
    .sync_o(unused_sclk_level),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  // cs_bar idles high; a falling edge selects, a rising edge deselects.
  spi_in_sync #(
    .SYNC_STAGES(SYNC_STAGES),
    .RESET_VAL  (1'b1)
  ) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (cs_bar),
    .sync_o(cs_s),
    .rise_o(desel),
    .fall_o(sel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mosi_sync_q <= '0;
    else        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

`ifdef SPI_SLAVE_ECHO_EN
  assign dflt_word = rx_data_q;
`else
  assign dflt_word = DEFAULT_TX_WORD[DATA_W-1:0];
`endif

  assign load_word   = buf_full_q ? buf_q : dflt_word;
  assign rx_word     = {rx_shift_q[DATA_W-2:0], mosi_s};
  assign bit_cnt_inc = bit_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    rx_data_d  = rx_data_q;
    rx_pend_d  = 1'b0;
    load       = 1'b0;
    // Deselect outranks any edge seen in the same cycle; a partial word
    // is dropped simply by clearing the counter.
    if (desel) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sel) begin
            load      = 1'b1;
            bit_cnt_d = '0;
            state_d   = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (sclk_rise) begin
            rx_shift_d = rx_word;
            if (bit_cnt_inc == CNT_W'(DATA_W)) begin
              rx_data_d = rx_word;
              rx_pend_d = 1'b1;
              bit_cnt_d = '0;
              state_d   = ST_RELOAD;
            end else begin
              bit_cnt_d = bit_cnt_inc;
            end
          end else if (sclk_fall) begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
        ST_RELOAD: begin
          // The fall after the last bit presents the next word's MSB.
          if (sclk_fall) begin
            load    = 1'b1;
            state_d = ST_SHIFT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (load) tx_shift_d = load_word;
  end

  // A write only happens while empty, so a coincident load has already
  // taken the old (empty) state and the new word waits for the next load.
  assign tx_write = tx_valid && !buf_full_q;

  always_comb begin
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (tx_write) begin
      buf_d      = tx_data;
      buf_full_d = 1'b1;
    end else if (load) begin
      buf_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      rx_data_q  <= '0;
      rx_pend_q  <= 1'b0;
      rx_valid_q <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      rx_data_q  <= rx_data_d;
      rx_pend_q  <= rx_pend_d;
      // rx_data settles one cycle ahead of the valid pulse.
      rx_valid_q <= rx_pend_q;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
    end
  end

  assign miso         = ~cs_s & tx_shift_q[DATA_W-1];
  assign miso_oe      = ~cs_s;
  assign tx_ready     = ~buf_full_q;
  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign frame_active = (state_q != ST_IDLE);

endmodule

// File: doc/spi_slave_responder.md
Name: spi_slave_responder

Overview:
SPI mode-0 slave (responder) for the far end of the SPI master link. Sits in the clk domain and oversamples the external sclk, cs_bar and mosi. Shifts in DATA_W-bit MSB-first frames and presents each received word with a one-cycle valid pulse. Shifts out a word preloaded through a valid/ready handshake. Used as the on-chip loopback partner and as an external slave.

Parameters:
DATA_W, 8, frame width in bits (MSB first)
SYNC_STAGES, 2, synchronizer depth for sclk/cs_bar/mosi (min 2)

Ports:
clk  input  1  system clock; sclk must be at most clk/8
reset  input  1  asynchronous, active-low reset
sclk  input  1  SPI clock from master, asynchronous
cs_bar  input  1  chip select, active-low, asynchronous
mosi  input  1  serial data from master
miso  output  1  serial data to master
miso_oe  output  1  miso drive enable; high while selected
tx_data  input  DATA_W  next word to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  one-entry tx buffer empty
rx_data  output  DATA_W  last fully received word
rx_valid  output  1  one-cycle pulse: rx_data updated
frame_active  output  1  high while selected and not idle

Behaviour:
- Reset (reset=0, async) puts the block in this state:
  - miso=0, miso_oe=0, rx_data=0, rx_valid=0, frame_active=0.
  - tx buffer empty, so tx_ready=1.
  - Shift register and bit counter cleared; state IDLE.
- Sync: sclk, cs_bar and mosi each pass SYNC_STAGES flops. A further flop on sclk_s and cs_s gives edge pulses rise/fall/sel/desel.
- TX buffer:
  - tx_ready = !buf_full (registered).
  - Write on tx_valid && tx_ready; buf_full sets next cycle.
  - A load into the shift register clears buf_full in the same cycle. A write is not accepted in that cycle.
- Load value:
  - buf_full=1: the buffer contents.
  - buf_full=0: the default word (see Optional Feature).
- FSM states:
  - IDLE: on sel (cs falling), load the shift register, bit_cnt=0, go to SHIFT.
  - SHIFT:
    - On rise: sample mosi_s into the LSB of rx_shift and increment bit_cnt.
    - On fall: shift tx_shift left by one.
    - When bit_cnt reaches DATA_W on a rise: rx_data<=rx_shift including the new bit, rx_valid=1 in the next cycle, bit_cnt=0, go to RELOAD.
  - RELOAD: on the next fall, load the shift register (back-to-back frames with no cs toggle), go to SHIFT.
  - Any state: desel (cs rising) returns to IDLE the next cycle.
- Abort: desel with 0<bit_cnt<DATA_W is a partial word.
  - The partial word is discarded; no rx_valid; bit_cnt cleared.
  - The consumed tx word is lost; it is not restored to the buffer.
- miso = tx_shift[DATA_W-1] while cs_s=0, else 0. miso_oe = !cs_s.
- frame_active = (state != IDLE).
- rx_valid latency: high exactly SYNC_STAGES+2 clk after the raw sclk rising edge of the last bit. Width is 1 cycle.
- Simultaneous events:
  - rise and desel in the same cycle: desel wins and the bit is dropped.
  - sel and tx write in the same cycle: the load uses the prior buffer state. The new word waits for the next load.
- Glitch: sel while already in SHIFT cannot occur, since desel is always processed first.

Optional Feature:
SPI_SLAVE_ECHO_EN.
- Defined: the default load word, used when the tx buffer is empty, is the last rx_data. The master reads back the previous word (echo/loopback test).
- Undefined: the default load word is all zeros.
- The handshake is identical in both builds.

Decomposition:
- Package spi_slave_pkg holds:
  - state enum typedef (IDLE, SHIFT, RELOAD);
  - DEFAULT_TX_WORD constant;
  - bit-count width function clog2(DATA_W+1).
- One sub-module, spi_in_sync: parameterised SYNC_STAGES synchronizer plus edge detector. It is instantiated for sclk and cs_bar; mosi uses the sync path only.

Test Plan:
- Reset mid-frame: assert reset after 3 bits -> all outputs at reset values immediately; next frame starts cleanly from bit 0.
- Single frame: tx write 0xA5, master sends 0x3C at clk/8 -> miso bits 1,0,1,0,0,1,0,1; rx_data=0x3C; rx_valid high 1 cycle; tx_ready back to 1.
- Back-to-back: buffer 0x11 then 0x22 (written during frame 1), master sends 0x80,0x01 under one cs_bar low -> rx_valid pulses twice with 0x80 then 0x01; miso returns 0x11 then 0x22.
- Empty buffer: no tx write, master sends 0x5A then 0xFF -> second frame returns 0x00; with SPI_SLAVE_ECHO_EN it returns 0x5A.
- Abort: cs_bar rises after 5 bits of 0xC3 -> no rx_valid, rx_data unchanged; next full frame 0x0F received correctly.
- Handshake: tx_valid held high with 0x77 while full -> tx_ready=0, no overwrite; accepted in the cycle after the load empties the buffer.
